// File: rtl/bist_pkg.sv
// Shared types, default parameters and sizing helper for the logic-BIST sequencer.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        COMPARE = 3'd4
    } bist_state_e;

    localparam int unsigned DEF_WIDTH         = 32;
    localparam int unsigned DEF_PATTERN_COUNT = 1024;
    localparam int unsigned DEF_DUT_LAT       = 1;
    localparam int unsigned DEF_PERIOD        = 65536;

    // Bits needed to hold every value 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bist_delay_line.sv
// DEPTH-stage shift pipeline aligning tpg_enable with the DUT response; flush clears every stage.
module bist_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign pipe_d = d_i;
        end else begin : g_multi
            assign pipe_d = {pipe_q[DEPTH-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (flush_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/bist_sequencer.sv
// Logic-BIST session controller: INIT -> RUN -> DRAIN -> COMPARE with abort to IDLE.
// Define BIST_PERIODIC_EN to also launch a session after PERIOD idle cycles.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned PATTERN_COUNT = DEF_PATTERN_COUNT,
    parameter int unsigned DUT_LAT       = DEF_DUT_LAT,
    parameter int unsigned PERIOD        = DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic [WIDTH-1:0] misr_signature,
    output logic             test_mode,
    output logic             tpg_seed_load,
    output logic             tpg_enable,
    output logic             misr_clear,
    output logic             misr_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output bist_state_e      dbg_state_o
);

    localparam int unsigned PC_W  = cnt_width(PATTERN_COUNT);
    localparam int unsigned LAT_W = cnt_width(DUT_LAT);

    bist_state_e      state_q;
    logic [PC_W-1:0]  pat_cnt_q;
    logic [LAT_W-1:0] drain_cnt_q;
    logic             test_mode_q;
    logic             seed_load_q;
    logic             tpg_enable_q;
    logic             misr_clear_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             fail_q;
    logic             trigger;

`ifdef BIST_PERIODIC_EN
    localparam int unsigned IC_W = cnt_width(PERIOD - 1);

    logic [IC_W-1:0] idle_cnt_q;
    logic            period_hit;

    assign period_hit = (idle_cnt_q == IC_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (state_q != IDLE || period_hit) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    assign trigger = start | period_hit;
`else
    assign trigger = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pat_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            test_mode_q  <= 1'b0;
            seed_load_q  <= 1'b0;
            tpg_enable_q <= 1'b0;
            misr_clear_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // abort wins over every transition, including the compare result and a new trigger
            if (abort) begin
                state_q      <= IDLE;
                pat_cnt_q    <= '0;
                drain_cnt_q  <= '0;
                test_mode_q  <= 1'b0;
                seed_load_q  <= 1'b0;
                tpg_enable_q <= 1'b0;
                misr_clear_q <= 1'b0;
                busy_q       <= 1'b0;
                pass_q       <= 1'b0;
                fail_q       <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (trigger) begin
                            state_q      <= INIT;
                            misr_clear_q <= 1'b1;
                            seed_load_q  <= 1'b1;
                            test_mode_q  <= 1'b1;
                            busy_q       <= 1'b1;
                            pass_q       <= 1'b0;
                            fail_q       <= 1'b0;
                        end
                    end
                    INIT: begin
                        state_q      <= RUN;
                        misr_clear_q <= 1'b0;
                        seed_load_q  <= 1'b0;
                        tpg_enable_q <= 1'b1;
                        pat_cnt_q    <= PC_W'(1);
                    end
                    RUN: begin
                        if (pat_cnt_q == PC_W'(PATTERN_COUNT)) begin
                            state_q      <= DRAIN;
                            tpg_enable_q <= 1'b0;
                            pat_cnt_q    <= '0;
                            drain_cnt_q  <= LAT_W'(1);
                        end else begin
                            pat_cnt_q <= pat_cnt_q + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt_q == LAT_W'(DUT_LAT)) begin
                            state_q     <= COMPARE;
                            drain_cnt_q <= '0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                    COMPARE: begin
                        state_q     <= IDLE;
                        test_mode_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= (misr_signature == golden_sig);
                        fail_q      <= (misr_signature != golden_sig);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    bist_delay_line #(
        .DEPTH (DUT_LAT)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort),
        .d_i     (tpg_enable_q),
        .q_o     (misr_enable)
    );

    assign test_mode     = test_mode_q;
    assign tpg_seed_load = seed_load_q;
    assign tpg_enable    = tpg_enable_q;
    assign misr_clear    = misr_clear_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: session-offset reference model with a stand-in signature analyser.
module tb_bist_sequencer;
    import bist_pkg::*;

    localparam int W    = 32;
    localparam int PC   = 4;
    localparam int LAT  = 1;
    localparam int PER  = 16;
    localparam int SESS = 2 + PC + LAT;  // session offset of the COMPARE cycle
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  golden_sig;
    logic [W-1:0]  misr_signature;
    logic          test_mode, tpg_seed_load, tpg_enable, misr_clear, misr_enable;
    logic          busy, done, pass, fail;
    bist_state_e   dbg_state;

    bist_sequencer #(
        .WIDTH(W), .PATTERN_COUNT(PC), .DUT_LAT(LAT), .PERIOD(PER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .golden_sig(golden_sig), .misr_signature(misr_signature),
        .test_mode(test_mode), .tpg_seed_load(tpg_seed_load), .tpg_enable(tpg_enable),
        .misr_clear(misr_clear), .misr_enable(misr_enable), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Stand-in analyser: signature = base XOR number of captures since the last clear.
    logic [W-1:0] sig_base = 32'hA5A5_1230;
    int unsigned  en_cnt = 0;
    always @(posedge clk) begin
        if (misr_clear)       en_cnt <= 0;
        else if (misr_enable) en_cnt <= en_cnt + 1;
    end
    assign misr_signature = sig_base ^ W'(en_cnt);

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // m_k: 0 in IDLE, otherwise cycles since the accepted start (1 = INIT .. SESS = COMPARE).
    int m_k, m_idle;
    bit m_done, m_pass, m_fail;

    function automatic logic [8:0] model_out(int k, bit d, bit p, bit f);
        logic tm, sl, te, mc, me, bz;
        tm = (k >= 1) && (k <= SESS);
        bz = tm;
        sl = (k == 1);
        mc = (k == 1);
        te = (k >= 2) && (k <= 1 + PC);
        me = (k >= 2 + LAT) && (k <= 1 + PC + LAT);
        return {tm, sl, te, mc, me, bz, d, p, f};
    endfunction

    task automatic model_reset();
        m_k = 0; m_idle = 0; m_done = 0; m_pass = 0; m_fail = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit match);
        bit idle_now;
        bit trig;
        idle_now = (m_k == 0);
        trig = st;
`ifdef BIST_PERIODIC_EN
        if (idle_now && m_idle == PER - 1) trig = 1'b1;
        if (idle_now) m_idle = (m_idle == PER - 1) ? 0 : m_idle + 1;
        else          m_idle = 0;
`endif
        m_done = 0;
        if (ab) begin
            m_k = 0; m_pass = 0; m_fail = 0;
        end else if (idle_now) begin
            if (trig) begin m_k = 1; m_pass = 0; m_fail = 0; end
        end else if (m_k == SESS) begin
            m_k = 0; m_done = 1; m_pass = match; m_fail = !match;
        end else begin
            m_k++;
        end
    endtask

    // ---------------- driver ----------------
    bit          start_v[MAXC];
    bit          abort_v[MAXC];
    logic [8:0]  exp_q[$];
    logic [8:0]  obs_q[$];

    function automatic logic [8:0] dut_vec();
        return {test_mode, tpg_seed_load, tpg_enable, misr_clear, misr_enable, busy, done, pass, fail};
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) begin start_v[i] = 0; abort_v[i] = 0; end
    endtask

    // Entered and left just after a rising edge; one iteration per clock cycle.
    task automatic run_cycles(input int n, input bit rand_gold);
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < n; c++) begin
            start = start_v[c];
            abort = abort_v[c];
            if (rand_gold)
                golden_sig = ($urandom_range(0, 1) == 1) ? (sig_base ^ W'(PC)) : W'($urandom());
            @(negedge clk);
            obs_q.push_back(dut_vec());
            exp_q.push_back(model_out(m_k, m_done, m_pass, m_fail));
            model_step(start_v[c], abort_v[c], golden_sig == (sig_base ^ W'(PC)));
            @(posedge clk);
            #1;
        end
        start = 0;
        abort = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; start = 0; abort = 0; golden_sig = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 9'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%b/%0d exp=%b/%0d", dut_vec(), dbg_state, 9'b0, IDLE);
        end
        rst_n = 1;
        model_reset();
        clear_sched();
        run_cycles(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_pass();
        int te_first, te_last, me_first, me_last;
        golden_sig = 32'hA5A5_1234;
        clear_sched();
        start_v[0] = 1;
        run_cycles(12, 0);
        te_first = -1; te_last = -1; me_first = -1; me_last = -1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL pass_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][6]) begin if (te_first < 0) te_first = i; te_last = i; end
            if (obs_q[i][4]) begin if (me_first < 0) me_first = i; me_last = i; end
        end
        checks++;
        if (te_first != 2 || te_last != 5 || me_first != 3 || me_last != 6) begin
            failures++;
            $display("FAIL pass_windows tpg=%0d..%0d misr=%0d..%0d exp tpg=2..5 misr=3..6",
                     te_first, te_last, me_first, me_last);
        end
        checks++;
        if (obs_q[8][2:0] !== 3'b110 || obs_q[7][2] !== 1'b0) begin
            failures++;
            $display("FAIL pass_done8 got=%b exp=110", obs_q[8][2:0]);
        end
    endtask

    task automatic test_fail();
        golden_sig = 32'hDEAD_BEEF;
        clear_sched();
        start_v[0] = 1;
        run_cycles(14, 0);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL fail_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[8][2:0] !== 3'b101 || obs_q[13][2:0] !== 3'b001) begin
            failures++;
            $display("FAIL fail_hold got8=%b got13=%b exp=101/001", obs_q[8][2:0], obs_q[13][2:0]);
        end
    endtask

    task automatic test_abort();
        bit bad;
        golden_sig = 32'hA5A5_1234;
        clear_sched();
        start_v[0] = 1;
        abort_v[4] = 1;
        run_cycles(12, 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
            if (i >= 5 && obs_q[i] !== 9'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_quiet outputs nonzero after cycle 5, exp all zero");
        end
    endtask

    task automatic test_start_ignored();
        int n_te, n_me;
        golden_sig = 32'hA5A5_1234;
        clear_sched();
        start_v[0] = 1; start_v[3] = 1; start_v[6] = 1;
        run_cycles(12, 0);
        n_te = 0; n_me = 0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ignore_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
            n_te += int'(obs_q[i][6]);
            n_me += int'(obs_q[i][4]);
        end
        checks++;
        if (n_te != PC || n_me != PC) begin
            failures++;
            $display("FAIL ignore_counts tpg=%0d misr=%0d exp=%0d", n_te, n_me, PC);
        end
    endtask

    task automatic test_start_with_abort();
        clear_sched();
        start_v[0] = 1; abort_v[0] = 1;
        run_cycles(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL start_abort cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        golden_sig = 32'hA5A5_1234;
        clear_sched();
        start_v[0] = 1;
        start_v[8] = 1;
        run_cycles(20, 0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[9][8] !== 1'b1 || obs_q[16][2] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_timing init9=%b done16=%b exp=1/1", obs_q[9][8], obs_q[16][2]);
        end
    endtask

    task automatic test_reset_mid();
        golden_sig = 32'hA5A5_1234;
        clear_sched();
        start_v[0] = 1;
        run_cycles(4, 0);
        rst_n = 0;
        #1;
        checks++;
        if (dut_vec() !== 9'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_mid got=%b/%0d exp=%b/%0d", dut_vec(), dbg_state, 9'b0, IDLE);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        clear_sched();
        start_v[0] = 1;
        run_cycles(10, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_resume cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[8][2:0] !== 3'b110) begin
            failures++;
            $display("FAIL reset_resume_done got=%b exp=110", obs_q[8][2:0]);
        end
    endtask

    task automatic test_random();
        clear_sched();
        for (int i = 0; i < 400; i++) begin
            start_v[i] = ($urandom_range(0, 5) == 0);
            abort_v[i] = ($urandom_range(0, 29) == 0);
        end
        run_cycles(400, 1);
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef BIST_PERIODIC_EN
    task automatic test_periodic();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        golden_sig = 32'hA5A5_1234;
        clear_sched();
        run_cycles(45, 0);
        for (int i = 0; i < 45; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL periodic cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[15][8] !== 1'b0 || obs_q[16][8] !== 1'b1 || obs_q[38][8] !== 1'b0 || obs_q[39][8] !== 1'b1) begin
            failures++;
            $display("FAIL periodic_init got15/16/38/39=%b%b%b%b exp=0101",
                     obs_q[15][8], obs_q[16][8], obs_q[38][8], obs_q[39][8]);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_abort();
        test_start_ignored();
        test_start_with_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef BIST_PERIODIC_EN
        test_periodic();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
